// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the MEM-stage load/store port.
// Word-organised data array split into four byte-lane arrays, RISC-V lane
// selection and load extension, programmable wait states, ack/busy handshake.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (misaligned accesses flag err,
// suppress the store and return zero instead of aligning down).
module dmem_responder #(
    parameter int DM_ADDRESS  = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [DM_ADDRESS-1:0] addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [2:0]            func3,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  ack,
    output logic                  busy,
    output logic                  err
);

    localparam int IDX_W = DM_ADDRESS - 2;
    localparam int DEPTH = 2 ** IDX_W;
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;

    // Request captured at acceptance; held for the whole transaction
    logic                  op_wr_reg;
    logic [DM_ADDRESS-1:0] addr_reg;
    logic [DATA_W-1:0]     wr_data_reg;
    logic [2:0]            func3_reg;

    logic [DATA_W-1:0] rd_data_reg;
    logic              ack_reg;

    logic              req_valid;
    logic              accept;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  wr_idx;
    wire  [DATA_W-1:0] rd_word;

    logic              is_byte;
    logic              is_half;
    logic              misaligned;
    logic [3:0]        byte_en;
    logic [DATA_W-1:0] store_data;
    logic              write_fire;

    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] load_val;

    assign req_valid = rd_en | wr_en;
    assign accept    = (state_reg == ST_IDLE) && req_valid;

    // State register and wait counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic: IDLE -> (WAIT) -> ACCESS -> DONE -> IDLE
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    if (WAIT_STATES > 0) begin
                        state_next = ST_WAIT;
                        cnt_next   = WAIT_INIT;
                    end else begin
                        state_next = ST_ACCESS;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = ST_ACCESS;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_ACCESS: state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Capture the request in IDLE; wr_en wins when both enables are high
    always_ff @(posedge clk) begin
        if (accept) begin
            op_wr_reg   <= wr_en;
            addr_reg    <= addr;
            wr_data_reg <= wr_data;
            func3_reg   <= func3;
        end
    end

    // Access size: stores only treat 000/001 as narrow, loads use func3[1:0]
    always_comb begin
        is_byte = 1'b0;
        is_half = 1'b0;
        if (op_wr_reg) begin
            is_byte = (func3_reg == 3'b000);
            is_half = (func3_reg == 3'b001);
        end else begin
            is_byte = (func3_reg[1:0] == 2'b00);
            is_half = (func3_reg[1:0] == 2'b01);
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    // Misalignment detection for halfword and word-class accesses
    always_comb begin
        misaligned = 1'b0;
        if (is_half) begin
            misaligned = addr_reg[0];
        end else if (!is_byte) begin
            misaligned = (addr_reg[1:0] != 2'b00);
        end
    end
`else
    assign misaligned = 1'b0;
`endif

    // Store lane steering: replicate narrow data across lanes, enable one lane set
    always_comb begin
        byte_en    = 4'b1111;
        store_data = wr_data_reg;
        if (is_byte) begin
            byte_en    = 4'b0001 << addr_reg[1:0];
            store_data = {4{wr_data_reg[7:0]}};
        end else if (is_half) begin
            byte_en    = addr_reg[1] ? 4'b1100 : 4'b0011;
            store_data = {2{wr_data_reg[15:0]}};
        end
    end

    // A reset sampled at the ACCESS edge cancels the write
    assign write_fire = (state_reg == ST_ACCESS) && op_wr_reg && reset && !misaligned;
    assign wr_idx     = addr_reg[DM_ADDRESS-1:2];

    // Read address follows the live bus in IDLE so the word is ready by ACCESS
    // even with zero wait states; afterwards it tracks the latched request.
    assign rd_idx = (state_reg == ST_IDLE) ? addr[DM_ADDRESS-1:2] : addr_reg[DM_ADDRESS-1:2];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_q_reg;

            // Byte-lane RAM with write enable and registered read
            always_ff @(posedge clk) begin
                if (write_fire && byte_en[gi]) begin
                    lane_mem[wr_idx] <= store_data[gi*8 +: 8];
                end
                lane_q_reg <= lane_mem[rd_idx];
            end

            assign rd_word[gi*8 +: 8] = lane_q_reg;
        end
    endgenerate

    // Load lane selection and sign/zero extension
    always_comb begin
        ld_byte  = rd_word[7:0];
        ld_half  = addr_reg[1] ? rd_word[31:16] : rd_word[15:0];
        load_val = rd_word;
        case (addr_reg[1:0])
            2'd0:    ld_byte = rd_word[7:0];
            2'd1:    ld_byte = rd_word[15:8];
            2'd2:    ld_byte = rd_word[23:16];
            default: ld_byte = rd_word[31:24];
        endcase
        case (func3_reg)
            3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_val = {24'd0, ld_byte};
            3'b101:  load_val = {16'd0, ld_half};
            default: load_val = rd_word;
        endcase
    end

    // Response registers: ack pulses in DONE, rd_data updates only on loads
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data_reg <= '0;
            ack_reg     <= 1'b0;
        end else begin
            ack_reg <= (state_reg == ST_ACCESS);
            if ((state_reg == ST_ACCESS) && !op_wr_reg) begin
                rd_data_reg <= misaligned ? '0 : load_val;
            end
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic err_reg;

    // Misalignment flag, visible only in the ack cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= (state_reg == ST_ACCESS) && misaligned;
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    assign rd_data = rd_data_reg;
    assign ack     = ack_reg;
    assign busy    = (state_reg == ST_WAIT) || (state_reg == ST_ACCESS) ||
                     ((state_reg == ST_IDLE) && req_valid);

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder
// (WAIT_STATES=1). Honours DMEM_MISALIGN_TRAP_EN for the misalign scenario.
module tb_dmem_responder;

    localparam int WS      = 1;
    localparam int LAT     = WS + 2;

    logic        clk;
    logic        reset;
    logic        rd_en;
    logic        wr_en;
    logic [8:0]  addr;
    logic [31:0] wr_data;
    logic [2:0]  func3;
    logic [31:0] rd_data;
    logic        ack;
    logic        busy;
    logic        err;

    int checks   = 0;
    int failures = 0;

    dmem_responder #(
        .DM_ADDRESS (9),
        .DATA_W     (32),
        .WAIT_STATES(WS)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .rd_en  (rd_en),
        .wr_en  (wr_en),
        .addr   (addr),
        .wr_data(wr_data),
        .func3  (func3),
        .rd_data(rd_data),
        .ack    (ack),
        .busy   (busy),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request, hold it until ack, report what was observed.
    // lat is the number of cycles from acceptance to ack (0 = no ack seen).
    task automatic req(input bit rd, input bit wr, input logic [8:0] a,
                       input logic [31:0] d, input logic [2:0] f3,
                       output logic [31:0] rdata, output logic err_o,
                       output int lat, output logic [7:0] busy_hist);
        busy_hist = 8'h00;
        rdata     = 32'h0;
        err_o     = 1'b0;
        lat       = 0;
        @(negedge clk);
        rd_en = rd; wr_en = wr; addr = a; wr_data = d; func3 = f3;
        #1 busy_hist[0] = busy;
        @(posedge clk);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i < 8) busy_hist[i] = busy;
            if (ack) begin
                lat   = i;
                rdata = rd_data;
                err_o = err;
                break;
            end
        end
        rd_en = 1'b0; wr_en = 1'b0;
        $display("txn rd=%0b wr=%0b addr=%h f3=%b wdata=%h lat=%0d rdata=%h err=%0b",
                 rd, wr, a, f3, d, lat, rdata, err_o);
    endtask

    task automatic test_reset();
        logic [31:0] rv; logic ev; int lat; logic [7:0] bh; int acks;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (rd_data !== 32'h0) begin failures++; $display("FAIL reset_rd_data got=%h exp=%h", rd_data, 32'h0); end
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", ack); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        reset = 1'b1;
        req(0, 1, 9'h010, 32'h0102_0304, 3'b010, rv, ev, lat, bh);
        req(1, 0, 9'h010, 32'h0, 3'b010, rv, ev, lat, bh);
        checks++; if (rv !== 32'h0102_0304) begin failures++; $display("FAIL reset_prior_lw got=%h exp=%h", rv, 32'h0102_0304); end
        // Store aborted by reset while in WAIT
        @(negedge clk);
        wr_en = 1'b1; addr = 9'h010; wr_data = 32'hDEAD_BEEF; func3 = 3'b010;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; wr_en = 1'b0;
        acks = 0;
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            if (ack) acks++;
        end
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (rd_data !== 32'h0) begin failures++; $display("FAIL abort_rd_data got=%h exp=%h", rd_data, 32'h0); end
        repeat (4) begin
            @(posedge clk); @(negedge clk);
            if (ack) acks++;
        end
        checks++; if (acks !== 0) begin failures++; $display("FAIL abort_ack_count got=%0d exp=0", acks); end
        $display("txn reset abort of SW 0x010, acks seen=%0d", acks);
        req(1, 0, 9'h010, 32'h0, 3'b010, rv, ev, lat, bh);
        checks++; if (rv !== 32'h0102_0304) begin failures++; $display("FAIL abort_lw got=%h exp=%h", rv, 32'h0102_0304); end
    endtask

    task automatic test_word_roundtrip();
        logic [31:0] rv; logic ev; int lat; logic [7:0] bh;
        req(0, 1, 9'h020, 32'h1234_5678, 3'b010, rv, ev, lat, bh);
        checks++; if (lat !== LAT) begin failures++; $display("FAIL sw_latency got=%0d exp=%0d", lat, LAT); end
        checks++; if (bh !== 8'b0000_0111) begin failures++; $display("FAIL sw_busy_hist got=%b exp=%b", bh, 8'b0000_0111); end
        req(1, 0, 9'h020, 32'h0, 3'b010, rv, ev, lat, bh);
        checks++; if (lat !== LAT) begin failures++; $display("FAIL lw_latency got=%0d exp=%0d", lat, LAT); end
        checks++; if (rv !== 32'h1234_5678) begin failures++; $display("FAIL lw_word got=%h exp=%h", rv, 32'h1234_5678); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rv; logic ev; int lat; logic [7:0] bh;
        req(0, 1, 9'h040, 32'h0, 3'b010, rv, ev, lat, bh);
        req(0, 1, 9'h042, 32'hABCD_EF80, 3'b000, rv, ev, lat, bh);
        req(1, 0, 9'h040, 32'h0, 3'b010, rv, ev, lat, bh);
        checks++; if (rv !== 32'h0080_0000) begin failures++; $display("FAIL sb_lw got=%h exp=%h", rv, 32'h0080_0000); end
        req(1, 0, 9'h042, 32'h0, 3'b000, rv, ev, lat, bh);
        checks++; if (rv !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb got=%h exp=%h", rv, 32'hFFFF_FF80); end
        req(1, 0, 9'h042, 32'h0, 3'b100, rv, ev, lat, bh);
        checks++; if (rv !== 32'h0000_0080) begin failures++; $display("FAIL lbu got=%h exp=%h", rv, 32'h0000_0080); end
        req(0, 1, 9'h041, 32'h1234_567F, 3'b000, rv, ev, lat, bh);
        req(1, 0, 9'h041, 32'h0, 3'b000, rv, ev, lat, bh);
        checks++; if (rv !== 32'h0000_007F) begin failures++; $display("FAIL lb_pos got=%h exp=%h", rv, 32'h0000_007F); end
        req(1, 0, 9'h040, 32'h0, 3'b010, rv, ev, lat, bh);
        checks++; if (rv !== 32'h0080_7F00) begin failures++; $display("FAIL sb2_lw got=%h exp=%h", rv, 32'h0080_7F00); end
    endtask

    task automatic test_halfword();
        logic [31:0] rv; logic ev; int lat; logic [7:0] bh;
        req(0, 1, 9'h044, 32'h0, 3'b010, rv, ev, lat, bh);
        req(0, 1, 9'h046, 32'h5555_8001, 3'b001, rv, ev, lat, bh);
        req(1, 0, 9'h046, 32'h0, 3'b001, rv, ev, lat, bh);
        checks++; if (rv !== 32'hFFFF_8001) begin failures++; $display("FAIL lh got=%h exp=%h", rv, 32'hFFFF_8001); end
        req(1, 0, 9'h046, 32'h0, 3'b101, rv, ev, lat, bh);
        checks++; if (rv !== 32'h0000_8001) begin failures++; $display("FAIL lhu got=%h exp=%h", rv, 32'h0000_8001); end
        req(1, 0, 9'h044, 32'h0, 3'b010, rv, ev, lat, bh);
        checks++; if (rv !== 32'h8001_0000) begin failures++; $display("FAIL sh_lw got=%h exp=%h", rv, 32'h8001_0000); end
        req(1, 0, 9'h044, 32'h0, 3'b011, rv, ev, lat, bh);
        checks++; if (rv !== 32'h8001_0000) begin failures++; $display("FAIL f3_011_as_lw got=%h exp=%h", rv, 32'h8001_0000); end
        req(1, 0, 9'h044, 32'h0, 3'b001, rv, ev, lat, bh);
        checks++; if (rv !== 32'h0000_0000) begin failures++; $display("FAIL lh_low got=%h exp=%h", rv, 32'h0); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] rv; logic ev; int lat; logic [7:0] bh;
        req(0, 1, 9'h050, 32'h0, 3'b010, rv, ev, lat, bh);
        req(1, 0, 9'h020, 32'h0, 3'b010, rv, ev, lat, bh);
        req(1, 1, 9'h050, 32'hA5A5_A5A5, 3'b010, rv, ev, lat, bh);
        checks++; if (lat !== LAT) begin failures++; $display("FAIL both_latency got=%0d exp=%0d", lat, LAT); end
        checks++; if (rv !== 32'h1234_5678) begin failures++; $display("FAIL both_rd_data_kept got=%h exp=%h", rv, 32'h1234_5678); end
        req(1, 0, 9'h050, 32'h0, 3'b010, rv, ev, lat, bh);
        checks++; if (rv !== 32'hA5A5_A5A5) begin failures++; $display("FAIL both_stored got=%h exp=%h", rv, 32'hA5A5_A5A5); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rv; logic ev; int lat; logic [7:0] bh; int acks; int bad_data; int to;
        req(0, 1, 9'h074, 32'h0, 3'b010, rv, ev, lat, bh);
        // Inputs changed during WAIT must be ignored
        @(negedge clk);
        wr_en = 1'b1; addr = 9'h070; wr_data = 32'h600D_CAFE; func3 = 3'b010;
        @(posedge clk);
        @(negedge clk);
        addr = 9'h074; wr_data = 32'hBAD0_BAD0; func3 = 3'b000;
        to = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack) begin to = 0; break; end
        end
        wr_en = 1'b0;
        checks++; if (to !== 0) begin failures++; $display("FAIL late_change_ack got=timeout exp=ack"); end
        $display("txn SW 0x070 with inputs changed mid-WAIT, timeout=%0d", to);
        req(1, 0, 9'h070, 32'h0, 3'b010, rv, ev, lat, bh);
        checks++; if (rv !== 32'h600D_CAFE) begin failures++; $display("FAIL late_change_70 got=%h exp=%h", rv, 32'h600D_CAFE); end
        req(1, 0, 9'h074, 32'h0, 3'b010, rv, ev, lat, bh);
        checks++; if (rv !== 32'h0) begin failures++; $display("FAIL late_change_74 got=%h exp=%h", rv, 32'h0); end
        // Continuous rd_en for 12 cycles: three requests back to back at spacing WS+3
        @(negedge clk);
        rd_en = 1'b1; addr = 9'h020; func3 = 3'b010;
        acks = 0; bad_data = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); @(negedge clk);
            if (ack) begin
                acks++;
                if (rd_data !== 32'h1234_5678) bad_data++;
                $display("txn back-to-back LW 0x020 ack at cycle %0d rdata=%h", k, rd_data);
            end
        end
        rd_en = 1'b0;
        #1;
        checks++; if (acks !== 3) begin failures++; $display("FAIL b2b_ack_count got=%0d exp=3", acks); end
        checks++; if (bad_data !== 0) begin failures++; $display("FAIL b2b_data got=%0d bad exp=0", bad_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_misalign();
        logic [31:0] rv; logic ev; int lat; logic [7:0] bh;
        req(0, 1, 9'h060, 32'h2222_2222, 3'b010, rv, ev, lat, bh);
        req(0, 1, 9'h061, 32'h1111_1111, 3'b010, rv, ev, lat, bh);
        checks++; if (lat !== LAT) begin failures++; $display("FAIL mis_sw_latency got=%0d exp=%0d", lat, LAT); end
`ifdef DMEM_MISALIGN_TRAP_EN
        checks++; if (ev !== 1'b1) begin failures++; $display("FAIL mis_sw_err got=%b exp=1", ev); end
        req(1, 0, 9'h060, 32'h0, 3'b010, rv, ev, lat, bh);
        checks++; if (rv !== 32'h2222_2222) begin failures++; $display("FAIL mis_sw_suppressed got=%h exp=%h", rv, 32'h2222_2222); end
        checks++; if (ev !== 1'b0) begin failures++; $display("FAIL mis_aligned_err got=%b exp=0", ev); end
        req(1, 0, 9'h062, 32'h0, 3'b010, rv, ev, lat, bh);
        checks++; if (rv !== 32'h0) begin failures++; $display("FAIL mis_lw_zero got=%h exp=%h", rv, 32'h0); end
        checks++; if (ev !== 1'b1) begin failures++; $display("FAIL mis_lw_err got=%b exp=1", ev); end
        #1;
        @(negedge clk);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL mis_err_after_ack got=%b exp=0", err); end
`else
        checks++; if (ev !== 1'b0) begin failures++; $display("FAIL mis_sw_err got=%b exp=0", ev); end
        req(1, 0, 9'h060, 32'h0, 3'b010, rv, ev, lat, bh);
        checks++; if (rv !== 32'h1111_1111) begin failures++; $display("FAIL mis_sw_aligned got=%h exp=%h", rv, 32'h1111_1111); end
        req(1, 0, 9'h062, 32'h0, 3'b010, rv, ev, lat, bh);
        checks++; if (rv !== 32'h1111_1111) begin failures++; $display("FAIL mis_lw_aligned got=%h exp=%h", rv, 32'h1111_1111); end
        checks++; if (ev !== 1'b0) begin failures++; $display("FAIL mis_lw_err got=%b exp=0", ev); end
`endif
    endtask

    initial begin
        reset = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
        addr = '0; wr_data = '0; func3 = '0;
        test_reset();
        test_word_roundtrip();
        test_byte_lanes();
        test_halfword();
        test_simultaneous();
        test_back_to_back();
        test_misalign();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
